// File: rtl/combolock_multi.sv
// combolock_multi
//   Multi-digit combination lock with a user-changeable combination, a
//   failed-attempt counter that escalates to ALARM, and auto-relock after a
//   timeout in OPEN. Drives an active-low seven-segment status pattern.
//
// Ports
//   Clock      : rising-edge clock for all state
//   Reset      : synchronous, active-high
//   switch     : digit value, sampled on a press
//   enter      : button level, rising edge is a press (open intent)
//   change     : button level, rising edge is a press (change-combo intent)
//   leds       : active-low seven-segment state pattern
//   unlocked   : high in OPEN
//   alarm      : high in ALARM
//   wrong      : high from a failed attempt until the next press/state change
//   fails      : consecutive failed attempts, saturating at MAX_TRIES
//   digit_idx  : digits captured in the current sequence
module combolock_multi #(
  parameter int                      WIDTH         = 4,
  parameter int                      DIGITS        = 3,
  parameter logic [WIDTH*DIGITS-1:0] DEFAULT_COMBO = 12'h612,
  parameter int                      MAX_TRIES     = 3,
  parameter int                      OPEN_TIMEOUT  = 16,
  parameter int                      ALARM_CYCLES  = 0,
  localparam int                     FW            = $clog2(MAX_TRIES + 1),
  localparam int                     IW            = $clog2(DIGITS + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] switch,
  input  logic             enter,
  input  logic             change,
  output logic [0:6]       leds,
  output logic             unlocked,
  output logic             alarm,
  output logic             wrong,
  output logic [FW-1:0]    fails,
  output logic [IW-1:0]    digit_idx
);

  // One timer serves both OPEN and ALARM; it only has to count up to the
  // larger of the two limits minus one.
  localparam int TMAX = (OPEN_TIMEOUT > ALARM_CYCLES) ? OPEN_TIMEOUT : ALARM_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int CW   = WIDTH * DIGITS;

  typedef enum logic [2:0] {
    S_LOCKED,
    S_CHECK,
    S_OPEN,
    S_NEW,
    S_ALARM
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   combo_q, combo_d;
  logic [CW-1:0]   entry_q, entry_d;
  logic [CW-1:0]   entry_wr;
  logic [IW-1:0]   idx_q, idx_d;
  logic [FW-1:0]   fails_q, fails_d;
  logic            wrong_q, wrong_d;
  logic            intent_q, intent_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            enter_q, change_q;
  logic            enter_press, change_press, one_press;
  logic            last_digit;

  // State register. During reset the edge registers follow the buttons, so a
  // button held through reset looks already-high afterwards and only counts
  // as a press after it is released and pressed again.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_LOCKED;
      combo_q  <= DEFAULT_COMBO;
      entry_q  <= '0;
      idx_q    <= '0;
      fails_q  <= '0;
      wrong_q  <= 1'b0;
      intent_q <= 1'b0;
      timer_q  <= '0;
      enter_q  <= enter;
      change_q <= change;
    end else begin
      state_q  <= state_d;
      combo_q  <= combo_d;
      entry_q  <= entry_d;
      idx_q    <= idx_d;
      fails_q  <= fails_d;
      wrong_q  <= wrong_d;
      intent_q <= intent_d;
      timer_q  <= timer_d;
      enter_q  <= enter;
      change_q <= change;
    end
  end

  // Press detection. Both buttons rising together is treated as no press at
  // all, so one_press is the exclusive-or of the two edges.
  always_comb begin
    enter_press  = enter & ~enter_q;
    change_press = change & ~change_q;
    one_press    = enter_press ^ change_press;
    last_digit   = (idx_q == IW'(DIGITS - 1));
  end

  // Entry buffer with the current switch value written into slot digit_idx.
  // Slot 0 lives in the most significant digit position.
  always_comb begin
    entry_wr = entry_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        entry_wr[(DIGITS - 1 - i) * WIDTH +: WIDTH] = switch;
      end
    end
  end

  // Next-state logic. The timer is cleared on every exit from OPEN/ALARM so
  // it always starts from zero on entry.
  always_comb begin
    state_d  = state_q;
    combo_d  = combo_q;
    entry_d  = entry_q;
    idx_d    = idx_q;
    fails_d  = fails_q;
    wrong_d  = wrong_q;
    intent_d = intent_q;
    timer_d  = timer_q;

    case (state_q)
      S_LOCKED: begin
        if (one_press) begin
          entry_d = entry_wr;
          wrong_d = 1'b0;
          if (last_digit) begin
            idx_d    = '0;
            intent_d = enter_press;
            state_d  = S_CHECK;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      S_CHECK: begin
        timer_d = '0;
        if (entry_q == combo_q) begin
          fails_d = '0;
          state_d = intent_q ? S_OPEN : S_NEW;
        end else if (fails_q == FW'(MAX_TRIES - 1)) begin
          fails_d = FW'(MAX_TRIES);
          state_d = S_ALARM;
        end else begin
          fails_d = fails_q + FW'(1);
          wrong_d = 1'b1;
          state_d = S_LOCKED;
        end
      end

      S_OPEN: begin
        if (one_press) begin
          timer_d = '0;
          state_d = S_LOCKED;
        end else if (OPEN_TIMEOUT != 0) begin
          if (timer_q == TW'(OPEN_TIMEOUT - 1)) begin
            timer_d = '0;
            state_d = S_LOCKED;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end

      S_NEW: begin
        if (one_press) begin
          entry_d = entry_wr;
          if (last_digit) begin
            combo_d = entry_wr;
            idx_d   = '0;
            fails_d = '0;
            state_d = S_LOCKED;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      S_ALARM: begin
        if (ALARM_CYCLES != 0) begin
          if (timer_q == TW'(ALARM_CYCLES - 1)) begin
            timer_d = '0;
            fails_d = '0;
            state_d = S_LOCKED;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end

      default: begin
        state_d = S_LOCKED;
      end
    endcase
  end

  // Output decode, purely from registered state.
  always_comb begin
    leds = 7'b1111110;
    case (state_q)
      S_NEW:   leds = 7'b1101010;
      S_ALARM: leds = 7'b0001000;
      S_OPEN:  leds = 7'b0000001;
      default: leds = 7'b1111110;
    endcase
    unlocked  = (state_q == S_OPEN);
    alarm     = (state_q == S_ALARM);
    wrong     = wrong_q;
    fails     = fails_q;
    digit_idx = idx_q;
  end

endmodule

// File: tb/tb_combolock_multi.sv
// tb_combolock_multi
//   Table-driven bench for combolock_multi. Each table row is one clock
//   cycle of inputs plus the outputs expected after that cycle's rising edge.
//   A second instance with ALARM_CYCLES=8 shares the inputs and is used for
//   the timed alarm exit.
module tb_combolock_multi;

  localparam logic [6:0] L_LOCK = 7'b1111110;
  localparam logic [6:0] L_NEW  = 7'b1101010;
  localparam logic [6:0] L_ALM  = 7'b0001000;
  localparam logic [6:0] L_OPEN = 7'b0000001;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       enter = 1'b0;
  logic       change = 1'b0;
  logic [3:0] sw = 4'd0;

  logic [0:6] leds, leds2;
  logic       unlocked, unlocked2;
  logic       alarm, alarm2;
  logic       wrong, wrong2;
  logic [1:0] fails, fails2;
  logic [1:0] digit_idx, digit_idx2;

  typedef struct {
    logic       rst;
    logic       en;
    logic       ch;
    logic [3:0] sw;
    logic [6:0] leds;
    logic       unl;
    logic       alm;
    logic       wrg;
    logic [1:0] fails;
    logic [1:0] idx;
  } vec_t;

  vec_t vec_table[$];
  vec_t exp_queue[$];
  int   check_count = 0;
  int   error_count = 0;
  int   vec_no = 0;

  // Clock generation
  always #5 Clock = ~Clock;

  combolock_multi dut (
    .Clock(Clock), .Reset(Reset), .switch(sw), .enter(enter), .change(change),
    .leds(leds), .unlocked(unlocked), .alarm(alarm), .wrong(wrong),
    .fails(fails), .digit_idx(digit_idx)
  );

  combolock_multi #(.ALARM_CYCLES(8)) dut_alarm (
    .Clock(Clock), .Reset(Reset), .switch(sw), .enter(enter), .change(change),
    .leds(leds2), .unlocked(unlocked2), .alarm(alarm2), .wrong(wrong2),
    .fails(fails2), .digit_idx(digit_idx2)
  );

  function automatic vec_t mk_vec(input logic rst, en, ch, input logic [3:0] s,
                                  input logic [6:0] l, input logic u, a, w,
                                  input logic [1:0] f, i);
    vec_t v;
    v.rst = rst; v.en = en; v.ch = ch; v.sw = s;
    v.leds = l; v.unl = u; v.alm = a; v.wrg = w; v.fails = f; v.idx = i;
    return v;
  endfunction

  task automatic lk(input logic en, ch, input logic [3:0] s, input logic w,
                    input logic [1:0] f, i);
    vec_table.push_back(mk_vec(1'b0, en, ch, s, L_LOCK, 1'b0, 1'b0, w, f, i));
  endtask

  task automatic op(input logic en, ch, input logic [3:0] s);
    vec_table.push_back(mk_vec(1'b0, en, ch, s, L_OPEN, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0));
  endtask

  task automatic nw(input logic en, ch, input logic [3:0] s, input logic [1:0] i);
    vec_table.push_back(mk_vec(1'b0, en, ch, s, L_NEW, 1'b0, 1'b0, 1'b0, 2'd0, i));
  endtask

  task automatic al(input logic en, ch, input logic [3:0] s);
    vec_table.push_back(mk_vec(1'b0, en, ch, s, L_ALM, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0));
  endtask

  task automatic rs(input logic en);
    vec_table.push_back(mk_vec(1'b1, en, 1'b0, 4'd0, L_LOCK, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
  endtask

  // Three enter presses; the last row is the CHECK cycle (digit_idx back to 0)
  task automatic enter_code(input logic [3:0] d0, d1, d2, input logic [1:0] f);
    lk(1, 0, d0, 0, f, 1); lk(0, 0, d0, 0, f, 1);
    lk(1, 0, d1, 0, f, 2); lk(0, 0, d1, 0, f, 2);
    lk(1, 0, d2, 0, f, 0);
  endtask

  // Pops the oldest expectation and compares it with the main instance
  task automatic checkOutput();
    vec_t e;
    logic [13:0] act, want;
    check_count++;
    if (exp_queue.size() == 0) begin
      error_count++;
      $display("[TB] FAIL scoreboard: got empty queue, required an entry");
    end else begin
      e = exp_queue.pop_front();
      act  = {leds, unlocked, alarm, wrong, fails, digit_idx};
      want = {e.leds, e.unl, e.alm, e.wrg, e.fails, e.idx};
      if (act !== want) begin
        error_count++;
        $display("[TB] FAIL vec%0d {leds,unl,alm,wrg,fails,idx}: got %b required %b",
                 vec_no, act, want);
      end
    end
    vec_no++;
  endtask

  // Drives one cycle of inputs on the falling edge, then checks after the rise
  task automatic applyStimulus(input vec_t v);
    @(negedge Clock);
    Reset  = v.rst;
    enter  = v.en;
    change = v.ch;
    sw     = v.sw;
    exp_queue.push_back(v);
    @(posedge Clock);
    #1;
    checkOutput();
  endtask

  task automatic run_table();
    foreach (vec_table[k]) applyStimulus(vec_table[k]);
    vec_table.delete();
  endtask

  task automatic check_alarm_dut(input int k, input logic a, input logic [6:0] l,
                                 input logic [1:0] f);
    check_count++;
    if ({leds2, alarm2, fails2} !== {l, a, f}) begin
      error_count++;
      $display("[TB] FAIL alarm_exit k=%0d {leds,alm,fails}: got %b required %b",
               k, {leds2, alarm2, fails2}, {l, a, f});
    end
  endtask

  // Watchdog so the run always ends even if something stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, required finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    vec_t v;

    // Reset values, then 6,1,2 opens two edges after the last press; relock after 16
    rs(0); rs(0);
    enter_code(6, 1, 2, 0); op(0, 0, 2);
    for (int k = 0; k < 15; k++) op(0, 0, 0);
    lk(0, 0, 0, 0, 0, 0);

    // Wrong code flags wrong/fails; the right code then opens and clears fails
    enter_code(6, 1, 3, 0); lk(0, 0, 3, 1, 1, 0);
    enter_code(6, 1, 2, 1); op(0, 0, 2);
    lk(0, 1, 0, 0, 0, 0); lk(0, 0, 0, 0, 0, 0);

    // Change combination to 9,9,4 through NEW
    lk(1, 0, 6, 0, 0, 1); lk(0, 0, 6, 0, 0, 1);
    lk(1, 0, 1, 0, 0, 2); lk(0, 0, 1, 0, 0, 2);
    lk(0, 1, 2, 0, 0, 0); nw(0, 0, 2, 0);
    nw(1, 0, 9, 1); nw(0, 0, 9, 1); nw(0, 1, 9, 2); nw(0, 0, 9, 2);
    lk(1, 0, 4, 0, 0, 0); lk(0, 0, 4, 0, 0, 0);
    enter_code(6, 1, 2, 0); lk(0, 0, 2, 1, 1, 0);
    enter_code(9, 9, 4, 1); op(0, 0, 4);
    lk(1, 0, 0, 0, 0, 0); lk(0, 0, 0, 0, 0, 0);

    // Simultaneous presses are ignored; a held button captures once
    lk(1, 1, 5, 0, 0, 0); lk(0, 0, 5, 0, 0, 0);
    lk(1, 0, 6, 0, 0, 1); lk(1, 0, 6, 0, 0, 1); lk(1, 0, 6, 0, 0, 1);
    lk(0, 0, 6, 0, 0, 1);

    // Reset mid-sequence, then reset mid-NEW with enter held through reset
    lk(1, 0, 1, 0, 0, 2); lk(0, 0, 1, 0, 0, 2); rs(0);
    lk(1, 0, 6, 0, 0, 1); lk(0, 0, 6, 0, 0, 1);
    lk(1, 0, 1, 0, 0, 2); lk(0, 0, 1, 0, 0, 2);
    lk(0, 1, 2, 0, 0, 0); nw(0, 0, 2, 0);
    nw(1, 0, 7, 1); nw(0, 0, 7, 1); nw(1, 0, 7, 2);
    rs(1); lk(1, 0, 7, 0, 0, 0); lk(0, 0, 7, 0, 0, 0);
    enter_code(6, 1, 2, 0); op(0, 0, 2);
    lk(0, 1, 0, 0, 0, 0); lk(0, 0, 0, 0, 0, 0);
    run_table();

    // Three wrong attempts reach ALARM on both instances
    rs(0); rs(0);
    enter_code(6, 1, 3, 0); lk(0, 0, 3, 1, 1, 0);
    enter_code(6, 1, 3, 1); lk(0, 0, 3, 1, 2, 0);
    enter_code(6, 1, 3, 2); al(0, 0, 3);
    run_table();
    check_alarm_dut(0, 1'b1, L_ALM, 2'd3);

    // Presses in ALARM are ignored; the timed instance leaves exactly 8 edges later
    for (int k = 1; k <= 8; k++) begin
      v = mk_vec(1'b0, (k == 2) || (k == 6), (k == 4) || (k == 6), 4'd6,
                 L_ALM, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0);
      applyStimulus(v);
      if (k < 8) check_alarm_dut(k, 1'b1, L_ALM, 2'd3);
      else       check_alarm_dut(k, 1'b0, L_LOCK, 2'd0);
    end

    // Sticky instance only recovers through reset, then the default code opens
    al(1, 0, 6); al(0, 0, 6); al(0, 1, 6);
    rs(0); rs(0);
    enter_code(6, 1, 2, 0); op(0, 0, 2);
    lk(1, 0, 0, 0, 0, 0);
    run_table();

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
